// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings, default timing constants and small helpers
// for the LED mode sequencer and its switch debouncer.
package led_ctrl_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ON   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SLOW = 2'd2;
  localparam logic [MODE_W-1:0] MODE_FAST = 2'd3;

  // 50 MHz clock: 20 ms debounce, 1 Hz slow blink, 5 Hz fast blink
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_SLOW_HALF       = 25_000_000;
  localparam int DEF_FAST_HALF       = 5_000_000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] nm;
    case (m)
      MODE_OFF:  nm = MODE_ON;
      MODE_ON:   nm = MODE_SLOW;
      MODE_SLOW: nm = MODE_FAST;
      MODE_FAST: nm = MODE_OFF;
      default:   nm = MODE_OFF;
    endcase
    return nm;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser, counter-based debouncer and rising-edge press
// detector for the raw switch input.
module sw_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iSW,
  output logic oSW_DB,
  output logic oPRESS
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sw_s1_q;
  logic             sw_s2_q;
  logic             db_q;
  logic             db_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce next state: any agreement with the current level restarts the count
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sw_s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      db_d  = sw_s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, debounce state and edge-detect history
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sw_s1_q   <= 1'b0;
      sw_s2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sw_s1_q   <= iSW;
      sw_s2_q   <= sw_s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign oSW_DB = db_q;
  // Single-cycle pulse on the debounced rising edge; releases are ignored
  assign oPRESS = db_q & ~db_prev_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Steps OFF -> ON -> BLINK_SLOW -> BLINK_FAST on each debounced press and
// drives the LED from registered mode and blink-phase state.
module led_mode_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SLOW_HALF       = DEF_SLOW_HALF,
  parameter int FAST_HALF       = DEF_FAST_HALF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSW,
  output logic              oLED,
  output logic [MODE_W-1:0] oMODE,
  output logic              oSW_DB
);

  localparam int                 BLINK_W   = cnt_width(SLOW_HALF);
  localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF - 1);
  localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF - 1);

  logic               press_s;
  logic [MODE_W-1:0]  mode_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_q;
  logic [BLINK_W-1:0] half_last_s;
  logic               led_s;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iSW   (iSW),
    .oSW_DB(oSW_DB),
    .oPRESS(press_s)
  );

  // Terminal count of the blink counter for the current mode
  always_comb begin
    case (mode_q)
      MODE_SLOW: half_last_s = SLOW_LAST;
      MODE_FAST: half_last_s = FAST_LAST;
      default:   half_last_s = SLOW_LAST;
    endcase
  end

  // Mode FSM and blink engine; a press wins over a blink terminal count
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (press_s) begin
      mode_q      <= next_mode(mode_q);
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      case (mode_q)
        MODE_SLOW, MODE_FAST: begin
          if (blink_cnt_q == half_last_s) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
          end
        end
        default: begin
          blink_cnt_q <= '0;
          phase_q     <= 1'b1;
        end
      endcase
    end
  end

  // LED decode from registered state only
  always_comb begin
    case (mode_q)
      MODE_OFF:  led_s = 1'b0;
      MODE_ON:   led_s = 1'b1;
      MODE_SLOW: led_s = phase_q;
      MODE_FAST: led_s = phase_q;
      default:   led_s = 1'b0;
    endcase
  end

  assign oLED  = led_s;
  assign oMODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with short debounce/blink timings.
module tb_led_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw;
  logic       led;
  logic [1:0] mode;
  logic       sw_db;

  int n_chk  = 0;
  int n_pass = 0;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_HALF      (8),
    .FAST_HALF      (2)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .iSW   (sw),
    .oLED  (led),
    .oMODE (mode),
    .oSW_DB(sw_db)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic exp_led(input logic [1:0] m, input int half, input int j);
    if (m == 2'd0)      return 1'b0;
    else if (m == 2'd1) return 1'b1;
    else                return ((j / half) % 2) == 0;
  endfunction

  // Hold the switch until the mode steps (edge 7), then release and watch the LED
  task automatic press(input logic [1:0] old_m, input logic [1:0] new_m,
                       input int half, input int ncyc);
    sw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_eq("press_sw_db", sw_db, (k >= 6) ? 32'd1 : 32'd0);
      chk_eq("press_mode", mode, (k == 7) ? new_m : old_m);
    end
    sw = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      if (j > 0) tick();
      chk_eq("mode_hold", mode, new_m);
      chk_eq("led", led, exp_led(new_m, half, j));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 1'b1;

    // Reset held for three edges with the switch high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("rst_mode", mode, 32'd0);
      chk_eq("rst_led", led, 32'd0);
      chk_eq("rst_sw_db", sw_db, 32'd0);
    end
    rst_n = 1'b1;
    sw    = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Glitch shorter than the debounce window
    sw = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    sw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_eq("glitch_sw_db", sw_db, 32'd0);
      chk_eq("glitch_mode", mode, 32'd0);
    end

    // Press/release, slow blink, fast blink, wrap to OFF
    press(2'd0, 2'd1, 0, 11);
    chk_eq("release_sw_db", sw_db, 32'd0);
    press(2'd1, 2'd2, 8, 48);
    press(2'd2, 2'd3, 2, 12);
    press(2'd3, 2'd0, 0, 10);

    // Back into slow blink, then reset during the LED-low half with switch held
    press(2'd0, 2'd1, 0, 8);
    press(2'd1, 2'd2, 8, 12);
    sw = 1'b1;
    tick();
    tick();
    chk_eq("pre_rst_mode", mode, 32'd2);
    chk_eq("pre_rst_led", led, 32'd0);
    rst_n = 1'b0;
    tick();
    chk_eq("mid_rst_mode", mode, 32'd0);
    chk_eq("mid_rst_led", led, 32'd0);
    chk_eq("mid_rst_sw_db", sw_db, 32'd0);
    rst_n = 1'b1;
    press(2'd0, 2'd1, 0, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
